// File: rtl/maxpool_sequencer_pkg.sv
// Shared constants and state encoding for the 14x14 -> 7x7 max-pool sequencer.
package maxpool_sequencer_pkg;

    localparam int MAP_DIM      = 14;
    localparam int POOL_DIM     = 7;
    localparam int POOL_WINDOWS = 49;
    localparam int IDX_W        = 6;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

endpackage

// File: rtl/maxpool_sequencer.sv
// Holds one feature map, steps an external 2x2 pooler through its 49 windows
// and presents the packed 7x7 result downstream with valid/ready.
module maxpool_sequencer
    import maxpool_sequencer_pkg::*;
#(
    parameter int IntSize = 8,
    parameter int MapDim  = MAP_DIM
) (
    input  logic                                       clk,
    input  logic                                       rst,
    input  logic                                       in_valid,
    output logic                                       in_ready,
    input  logic [IntSize*MapDim*MapDim-1:0]           in_map,
    output logic [IntSize*MapDim*MapDim-1:0]           pool_data,
    output logic [IDX_W-1:0]                           pool_state,
    input  logic [IntSize-1:0]                         pool_in,
    output logic                                       out_valid,
    input  logic                                       out_ready,
    output logic [IntSize*(MapDim/2)*(MapDim/2)-1:0]   out_data,
    output logic                                       busy
);

    localparam int                 Windows = (MapDim / 2) * (MapDim / 2);
    localparam logic [IDX_W-1:0]   LastIdx = IDX_W'(Windows - 1);

    state_t                                     r_state;
    state_t                                     w_next;
    logic [IDX_W-1:0]                           r_idx;
    logic [IntSize*MapDim*MapDim-1:0]           r_pool_data;
    logic [IntSize*(MapDim/2)*(MapDim/2)-1:0]   r_out_data;
    logic                                       r_out_valid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_idx       <= '0;
            r_pool_data <= '0;
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
        end else begin
            r_state <= w_next;
            case (r_state)
                ST_IDLE: begin
                    if (in_valid) begin
                        r_pool_data <= in_map;
                        r_idx       <= '0;
                    end
                end
                ST_RUN: begin
                    r_out_data[r_idx*IntSize +: IntSize] <= pool_in;
                    // idx parks at the last window rather than wrapping
                    if (r_idx == LastIdx) begin
                        r_out_valid <= 1'b1;
                    end else begin
                        r_idx <= r_idx + 1'b1;
                    end
                end
                ST_HOLD: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        w_next     = r_state;
        in_ready   = 1'b0;
        busy       = 1'b0;
        pool_state = '0;
        case (r_state)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) w_next = ST_RUN;
            end
            ST_RUN: begin
                busy       = 1'b1;
                pool_state = r_idx;
                if (r_idx == LastIdx) w_next = ST_HOLD;
            end
            ST_HOLD: begin
                busy = 1'b1;
                if (out_ready) w_next = ST_IDLE;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    assign pool_data = r_pool_data;
    assign out_data  = r_out_data;
    assign out_valid = r_out_valid;

endmodule

// File: tb/tb_maxpool_sequencer.sv
// Bench for maxpool_sequencer: behavioural 2x2 pooler, timeline model and
// per-cycle compare plus directed literal checks.
module tb_maxpool_sequencer;

    localparam int N_IN  = 196 * 8;
    localparam int N_OUT = 49 * 8;

    logic               clk = 1'b0;
    logic               rst;
    logic               in_valid;
    logic               in_ready;
    logic [N_IN-1:0]    in_map;
    logic [N_IN-1:0]    pool_data;
    logic [5:0]         pool_state;
    logic [7:0]         pool_in;
    logic               out_valid;
    logic               out_ready;
    logic [N_OUT-1:0]   out_data;
    logic               busy;

    integer n_vec = 0;
    integer n_err = 0;

    maxpool_sequencer #(.IntSize(8), .MapDim(14)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_map     (in_map),
        .pool_data  (pool_data),
        .pool_state (pool_state),
        .pool_in    (pool_in),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    // Max of the 2x2 window k (k = 7*r + c) of a 14x14 unsigned map.
    function automatic logic [7:0] win_max(input logic [N_IN-1:0] m, input int k);
        int r;
        int c;
        logic [7:0] best;
        logic [7:0] v;
        r = k / 7;
        c = k % 7;
        best = 8'd0;
        for (int dr = 0; dr < 2; dr++) begin
            for (int dc = 0; dc < 2; dc++) begin
                v = m[((2*r + dr)*14 + 2*c + dc)*8 +: 8];
                if (v > best) best = v;
            end
        end
        return best;
    endfunction

    function automatic logic [N_OUT-1:0] pool_all(input logic [N_IN-1:0] m);
        logic [N_OUT-1:0] res;
        res = '0;
        for (int k = 0; k < 49; k++) res[k*8 +: 8] = win_max(m, k);
        return res;
    endfunction

    always_comb begin
        pool_in = 8'd0;
        if (pool_state < 6'd49) pool_in = win_max(pool_data, int'(pool_state));
    end

    task automatic chk(input string name, input logic [N_IN-1:0] act, input logic [N_IN-1:0] exp);
        n_vec = n_vec + 1;
        if (act !== exp) begin
            n_err = n_err + 1;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Timeline model: after an accepted map, 49 capture cycles, then hold
    // until out_ready.
    int               m_left;
    logic             m_hold;
    logic [N_IN-1:0]  m_map;
    logic [N_OUT-1:0] m_res;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_left <= 0;
            m_hold <= 1'b0;
            m_map  <= '0;
            m_res  <= '0;
        end else if (m_left == 0 && !m_hold) begin
            if (in_valid) begin
                m_map  <= in_map;
                m_left <= 49;
            end
        end else if (m_left > 0) begin
            m_left <= m_left - 1;
            if (m_left == 1) begin
                m_hold <= 1'b1;
                m_res  <= pool_all(m_map);
            end
        end else if (out_ready) begin
            m_hold <= 1'b0;
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            chk("in_ready", N_IN'(in_ready), N_IN'(m_left == 0 && !m_hold));
            chk("busy", N_IN'(busy), N_IN'(m_left > 0 || m_hold));
            chk("out_valid", N_IN'(out_valid), N_IN'(m_hold));
            chk("pool_data", pool_data, m_map);
            chk("pool_state", N_IN'(pool_state), N_IN'(m_left > 0 ? 49 - m_left : 0));
            if (m_left == 0) chk("out_data", N_IN'(out_data), N_IN'(m_res));
        end
    end

    task automatic accept(input logic [N_IN-1:0] m);
        @(negedge clk);
        in_map   = m;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic run_map(input string name, input logic [N_IN-1:0] m);
        accept(m);
        repeat (48) @(posedge clk);
        #1 chk({name, "_ov_c48"}, N_IN'(out_valid), N_IN'(0));
        @(posedge clk);
        #1 chk({name, "_ov_c49"}, N_IN'(out_valid), N_IN'(1));
        chk({name, "_data"}, N_IN'(out_data), N_IN'(pool_all(m)));
    endtask

    task automatic handshake(input string name);
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk({name, "_ov_low"}, N_IN'(out_valid), N_IN'(0));
        chk({name, "_in_ready"}, N_IN'(in_ready), N_IN'(1));
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic wait_ov(input string name);
        for (int i = 0; i < 100; i++) begin
            @(posedge clk);
            #1;
            if (out_valid) break;
        end
        chk({name, "_timeout"}, N_IN'(out_valid), N_IN'(1));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    logic [N_IN-1:0] map_a;
    logic [N_IN-1:0] map_b;
    logic [N_IN-1:0] map_c;
    logic [N_IN-1:0] map_ff;
    logic [N_IN-1:0] map_00;

    initial begin
        for (int i = 0; i < 196; i++) begin
            map_a[i*8 +: 8] = 8'(i);
            map_b[i*8 +: 8] = 8'((i * 7 + 3) % 256);
            map_c[i*8 +: 8] = 8'(255 - i);
        end
        map_ff = '1;
        map_00 = '0;

        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        in_map = '0;
        #12;
        chk("rst_in_ready", N_IN'(in_ready), N_IN'(1));
        chk("rst_out_valid", N_IN'(out_valid), N_IN'(0));
        chk("rst_busy", N_IN'(busy), N_IN'(0));
        chk("rst_pool_state", N_IN'(pool_state), N_IN'(0));
        chk("rst_pool_data", pool_data, N_IN'(0));
        chk("rst_out_data", N_IN'(out_data), N_IN'(0));
        @(negedge clk);
        rst = 1'b0;

        // ramp map: literal window maxima
        run_map("ramp", map_a);
        chk("ramp_b0", N_IN'(out_data[0*8 +: 8]), N_IN'(15));
        chk("ramp_b1", N_IN'(out_data[1*8 +: 8]), N_IN'(17));
        chk("ramp_b7", N_IN'(out_data[7*8 +: 8]), N_IN'(43));
        chk("ramp_b48", N_IN'(out_data[48*8 +: 8]), N_IN'(195));

        // back-pressure for 20 cycles
        repeat (20) begin
            @(negedge clk);
            chk("bp_ov", N_IN'(out_valid), N_IN'(1));
            chk("bp_b48", N_IN'(out_data[48*8 +: 8]), N_IN'(195));
            chk("bp_in_ready", N_IN'(in_ready), N_IN'(0));
        end
        handshake("bp");

        // in_valid held high across two maps
        @(negedge clk);
        in_map = map_b;
        in_valid = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_map = map_c;
        wait_ov("b2b_first");
        chk("b2b_first_data", N_IN'(out_data), N_IN'(pool_all(map_b)));
        @(posedge clk);
        #1 chk("b2b_idle_ready", N_IN'(in_ready), N_IN'(1));
        @(posedge clk);
        #1;
        chk("b2b_second_busy", N_IN'(busy), N_IN'(1));
        chk("b2b_second_map", pool_data, map_c);
        @(negedge clk);
        in_valid = 1'b0;
        wait_ov("b2b_second");
        chk("b2b_second_data", N_IN'(out_data), N_IN'(pool_all(map_c)));
        @(posedge clk);
        #1 chk("b2b_done_ready", N_IN'(in_ready), N_IN'(1));
        @(negedge clk);
        out_ready = 1'b0;

        // asynchronous reset at idx=20
        accept(map_a);
        repeat (20) @(posedge clk);
        #1 chk("arst_pre_state", N_IN'(pool_state), N_IN'(20));
        #2 rst = 1'b1;
        #1;
        chk("arst_busy", N_IN'(busy), N_IN'(0));
        chk("arst_in_ready", N_IN'(in_ready), N_IN'(1));
        chk("arst_pool_state", N_IN'(pool_state), N_IN'(0));
        chk("arst_pool_data", pool_data, N_IN'(0));
        chk("arst_out_data", N_IN'(out_data), N_IN'(0));
        chk("arst_out_valid", N_IN'(out_valid), N_IN'(0));
        @(negedge clk);
        #2 rst = 1'b0;
        repeat (60) begin
            @(negedge clk);
            chk("arst_ov_quiet", N_IN'(out_valid), N_IN'(0));
        end
        run_map("arst_new", map_b);
        handshake("arst_new");

        // every byte rewritten each run
        run_map("all_ff", map_ff);
        handshake("all_ff");
        run_map("all_00", map_00);
        handshake("all_00");

        // in_valid ignored in RUN and HOLD
        accept(map_a);
        repeat (10) @(negedge clk);
        in_map = map_ff;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        chk("ign_run_map", pool_data, map_a);
        wait_ov("ign");
        @(negedge clk);
        in_map = map_00;
        in_valid = 1'b1;
        repeat (3) @(negedge clk);
        chk("ign_hold_ov", N_IN'(out_valid), N_IN'(1));
        chk("ign_hold_map", pool_data, map_a);
        in_valid = 1'b0;
        handshake("ign");
        @(posedge clk);
        #1;
        chk("ign_no_restart", N_IN'(busy), N_IN'(0));
        chk("ign_data_kept", N_IN'(out_data), N_IN'(pool_all(map_a)));

        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
